open_list_arbiter: RTL and testbench

- Shares one open_list_queue instance among NUM_REQ requesters (A* neighbour-expansion lanes and the node-selection stage).
- Requesters issue enqueue (push f-cost) or dequeue (pop minimum f-cost) requests. The arbiter grants one requester at a time in round-robin order and sequences the queue's write/read strobes.
- Returns an ack, popped data and an error flag to the granted requester.
- Sits between the expansion lanes and the open_list_queue in the pathfinding core.

---
 rtl/open_list_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/open_list_arbiter.sv | 163 ++++++++++++++++
 tb/tb_open_list_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/open_list_pkg.sv
// Shared types for the open-list queue and its requester arbiter.
package open_list_pkg;

    localparam int OL_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ENQ,
        DEQ,
        ACK
    } ol_state_e;

    typedef enum logic {
        OP_WR,
        OP_RD
    } ol_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request above the last winner, wrapping.
module rr_arbiter
    import open_list_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       grant_en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int               c;
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        c         = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cand = IDX_W'(c);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Pointer parks on the last winner so it gets lowest priority next time.
    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (grant_en && grant_any) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/open_list_arbiter.sv
// Serialises enqueue/dequeue requests from several lanes onto one open_list_queue.
module open_list_arbiter
    import open_list_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = OL_DATA_WIDTH,
    parameter int READ_CYCLES = 2
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic [NUM_REQ-1:0]            req_wrt,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_node_f,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          rsp_err,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_node_f,
    output logic                          q_wrt,
    output logic                          q_read,
    output logic                          q_valid,
    output logic [DATA_WIDTH-1:0]         q_node_f,
    input  logic                          q_full,
    input  logic                          q_empty,
    input  logic                          q_o_valid,
    input  logic [DATA_WIDTH-1:0]         q_o_node_f
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(READ_CYCLES - 1);

    ol_state_e             state;
    ol_op_e                lat_op;
    logic [IDX_W-1:0]      lat_idx;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic [CNT_W-1:0]      rd_cnt;

    logic [NUM_REQ-1:0]    req_any;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_valid;
    logic                  win_wr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REQ-1:0]    lat_onehot;
    logic                  pop_err;
    logic [DATA_WIDTH-1:0] pop_data;

    assign req_any    = req_wrt | req_read;
    assign win_wr     = |(win_onehot & req_wrt);
    assign lat_onehot = NUM_REQ'(1) << lat_idx;
    assign q_node_f   = q_wrt ? lat_data : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .req       (req_any),
        .grant_en  (state == IDLE),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .grant_any (win_valid)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_data = req_node_f[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The head is only trusted on the first read cycle; later cycles replay it.
    always_comb begin
        if (rd_cnt == '0) begin
            pop_err  = !q_o_valid;
            pop_data = q_o_valid ? q_o_node_f : '0;
        end else begin
            pop_err  = rd_err;
            pop_data = rd_data;
        end
    end

    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            state      <= IDLE;
            lat_op     <= OP_WR;
            lat_idx    <= '0;
            lat_data   <= '0;
            rd_data    <= '0;
            rd_err     <= 1'b0;
            rd_cnt     <= '0;
            req_ack    <= '0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_node_f <= '0;
            q_wrt      <= 1'b0;
            q_read     <= 1'b0;
            q_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        lat_idx  <= win_idx;
                        lat_op   <= win_wr ? OP_WR : OP_RD;
                        lat_data <= win_data;
                        rd_cnt   <= '0;
                        if ((win_wr && q_full) || (!win_wr && q_empty)) begin
                            state      <= ACK;
                            req_ack    <= win_onehot;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b0;
                            rsp_node_f <= '0;
                        end else if (win_wr) begin
                            state   <= ENQ;
                            q_wrt   <= 1'b1;
                            q_valid <= 1'b1;
                        end else begin
                            state   <= DEQ;
                            q_read  <= 1'b1;
                            q_valid <= 1'b1;
                        end
                    end
                end
                ENQ: begin
                    state      <= ACK;
                    q_wrt      <= 1'b0;
                    q_valid    <= 1'b0;
                    req_ack    <= lat_onehot;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b0;
                    rsp_node_f <= '0;
                end
                DEQ: begin
                    rd_cnt  <= rd_cnt + 1'b1;
                    rd_err  <= pop_err;
                    rd_data <= pop_data;
                    if (rd_cnt == LAST_RD) begin
                        state      <= ACK;
                        q_read     <= 1'b0;
                        q_valid    <= 1'b0;
                        req_ack    <= lat_onehot;
                        rsp_err    <= pop_err;
                        rsp_valid  <= (lat_op == OP_RD) && !pop_err;
                        rsp_node_f <= pop_data;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    req_ack    <= '0;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b0;
                    rsp_node_f <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_open_list_arbiter.sv
// Bench for open_list_arbiter: sorted-queue stub, transaction-level model, directed scenarios.
module tb_open_list_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int RC    = 2;
    localparam int QSIZE = 4;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b1;
    logic [NR-1:0]    req_wrt = '0;
    logic [NR-1:0]    req_read = '0;
    logic [NR*DW-1:0] req_node_f = '0;
    logic [NR-1:0]    req_ack;
    logic             rsp_err, rsp_valid;
    logic [DW-1:0]    rsp_node_f;
    logic             q_wrt, q_read, q_valid;
    logic [DW-1:0]    q_node_f;
    logic             q_full, q_empty, q_o_valid;
    logic [DW-1:0]    q_o_node_f;

    open_list_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .READ_CYCLES (RC)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .req_wrt    (req_wrt),
        .req_read   (req_read),
        .req_node_f (req_node_f),
        .req_ack    (req_ack),
        .rsp_err    (rsp_err),
        .rsp_valid  (rsp_valid),
        .rsp_node_f (rsp_node_f),
        .q_wrt      (q_wrt),
        .q_read     (q_read),
        .q_valid    (q_valid),
        .q_node_f   (q_node_f),
        .q_full     (q_full),
        .q_empty    (q_empty),
        .q_o_valid  (q_o_valid),
        .q_o_node_f (q_o_node_f)
    );

    always #5 CLK = ~CLK;

    // Min-priority queue stub: push on q_wrt, pop once at the start of a q_read burst.
    logic [DW-1:0] sq [QSIZE] = '{default: '0};
    int            scnt = 0;
    logic          q_rd_d = 1'b0;

    always @(posedge CLK) begin
        logic [DW-1:0] t [QSIZE];
        int c, p;
        t = sq;
        c = scnt;
        if (q_wrt && c < QSIZE) begin
            p = c;
            while (p > 0 && t[p-1] > q_node_f) begin
                t[p] = t[p-1];
                p--;
            end
            t[p] = q_node_f;
            c++;
        end
        if (q_read && !q_rd_d && c > 0) begin
            for (int k = 0; k < QSIZE - 1; k++) t[k] = t[k+1];
            c--;
        end
        sq     <= t;
        scnt   <= c;
        q_rd_d <= q_read;
    end

    assign q_o_node_f = sq[0];
    assign q_o_valid  = (scnt > 0);
    assign q_full     = (scnt == QSIZE);
    assign q_empty    = (scnt == 0);

    logic [NR-1:0] pa_req = '0;
    logic [NR-1:0] pa_ack = '0;
    always @(negedge CLK) begin
        for (int i = 0; i < NR; i++) begin
            assert (!(pa_req[i] && !(req_wrt[i] | req_read[i]) && !pa_ack[i]))
                else $error("protocol: requester %0d withdrew before ack", i);
        end
        pa_req <= req_wrt | req_read;
        pa_ack <= req_ack;
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    int            m_ptr = NR - 1;
    bit            m_busy = 0;
    int            m_t = 0;
    int            m_idx = 0;
    bit            m_wr = 0;
    bit            m_err = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] mq [$];

    int            ack_cnt  [NR] = '{default: 0};
    int            ack_cyc  [NR] = '{default: 0};
    int            req_cyc  [NR] = '{default: 0};
    logic [DW-1:0] ack_data [NR] = '{default: '0};
    bit            ack_err  [NR] = '{default: 0};
    bit            ack_val  [NR] = '{default: 0};
    int            ack_order [$];
    logic [NR-1:0] ack_seen = '0;
    int            qwrt_n = 0;
    int            qread_n = 0;

    task automatic ck(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int min_idx();
        int b = 0;
        for (int k = 1; k < mq.size(); k++) if (mq[k] < mq[b]) b = k;
        return b;
    endfunction

    // Transaction model: a granted op owns a fixed timeline measured from its decision cycle.
    task automatic model_check();
        logic [NR-1:0] e_ack, reqs;
        logic          e_err, e_val, e_wrt, e_rd, e_qv, at_ack;
        logic [DW-1:0] e_rnf, e_qnf;
        bit            chk_rnf, chk_qnf;
        int            w, c;
        e_ack = '0; e_err = 0; e_val = 0; e_wrt = 0; e_rd = 0; e_qv = 0; at_ack = 0;
        e_rnf = '0; e_qnf = '0; chk_rnf = 0; chk_qnf = 0; w = -1;
        if (RSTn) begin
            m_busy = 0;
            m_ptr = NR - 1;
            chk_rnf = 1;
            chk_qnf = 1;
        end else if (m_busy) begin
            m_t++;
            if (m_err) begin
                at_ack = (m_t == 1);
            end else if (m_wr) begin
                if (m_t == 1) begin
                    e_wrt = 1; e_qv = 1; e_qnf = m_data; chk_qnf = 1;
                end
                at_ack = (m_t == 2);
            end else begin
                if (m_t <= RC) begin
                    e_rd = 1; e_qv = 1;
                end
                at_ack = (m_t == RC + 1);
            end
            if (at_ack) begin
                e_ack[m_idx] = 1'b1;
                e_err = m_err;
                e_val = !m_wr && !m_err;
                e_rnf = e_val ? m_data : '0;
                chk_rnf = 1;
                m_busy = 0;
                if (!m_err) begin
                    if (m_wr) mq.push_back(m_data);
                    else mq.delete(min_idx());
                end
            end
        end else begin
            reqs = req_wrt | req_read;
            for (int k = 1; k <= NR; k++) begin
                c = (m_ptr + k) % NR;
                if (w < 0 && reqs[c]) w = c;
            end
            if (w >= 0) begin
                m_ptr = w; m_idx = w; m_wr = req_wrt[w]; m_busy = 1; m_t = 0;
                if (m_wr) begin
                    m_err  = (mq.size() == QSIZE);
                    m_data = req_node_f[w*DW +: DW];
                end else begin
                    m_err  = (mq.size() == 0);
                    m_data = m_err ? '0 : mq[min_idx()];
                end
            end
        end

        ck("req_ack", DW'(req_ack), DW'(e_ack));
        ck("rsp_err", DW'(rsp_err), DW'(e_err));
        ck("rsp_valid", DW'(rsp_valid), DW'(e_val));
        ck("q_wrt", DW'(q_wrt), DW'(e_wrt));
        ck("q_read", DW'(q_read), DW'(e_rd));
        ck("q_valid", DW'(q_valid), DW'(e_qv));
        ck("q_wrt_read_excl", DW'(q_wrt & q_read), '0);
        if (chk_rnf) ck("rsp_node_f", rsp_node_f, e_rnf);
        if (chk_qnf) ck("q_node_f", q_node_f, e_qnf);

        if (q_wrt) qwrt_n++;
        if (q_read) qread_n++;
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                ack_cyc[i]  = cyc;
                ack_data[i] = rsp_node_f;
                ack_err[i]  = rsp_err;
                ack_val[i]  = rsp_valid;
                ack_order.push_back(i);
            end
        end
        ack_seen = req_ack;
    endtask

    // One clock: check at the falling edge, then drop acked requests just after the rising edge.
    task automatic step();
        logic [NR-1:0] done;
        @(negedge CLK);
        model_check();
        done = ack_seen;
        @(posedge CLK);
        cyc++;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (done[i]) begin
                if (req_wrt[i]) req_wrt[i] = 1'b0;
                else req_read[i] = 1'b0;
            end
        end
        ack_seen = '0;
    endtask

    task automatic issue(input int i, input bit wr, input logic [DW-1:0] d);
        if (wr) begin
            req_node_f[i*DW +: DW] = d;
            req_wrt[i] = 1'b1;
        end else begin
            req_read[i] = 1'b1;
        end
        req_cyc[i] = cyc;
    endtask

    task automatic wait_ack(input int i, input int n0);
        int b = 0;
        while (ack_cnt[i] == n0 && b < 40) begin
            step();
            b++;
        end
        ck($sformatf("ack_arrived_req%0d", i), DW'(ack_cnt[i] > n0), 1);
    endtask

    task automatic op(input int i, input bit wr, input logic [DW-1:0] d);
        int n0 = ack_cnt[i];
        issue(i, wr, d);
        wait_ack(i, n0);
    endtask

    initial begin
        logic [DW-1:0] enq_v [4] = '{5, 2, 3, 7};
        logic [DW-1:0] deq_v [4] = '{2, 3, 5, 7};
        int n0, w0, r0, rel;

        repeat (3) step();
        ck("rst_req_ack", DW'(req_ack), '0);
        ck("rst_q_valid", DW'(q_valid), '0);
        RSTn = 1'b0;

        for (int k = 0; k < 4; k++) begin
            op(0, 1, enq_v[k]);
            ck("enq_latency", DW'(ack_cyc[0] - req_cyc[0]), 2);
            ck("enq_err", DW'(ack_err[0]), 0);
        end
        ck("full_after_4", DW'(q_full), 1);
        for (int k = 0; k < 4; k++) begin
            op(0, 0, '0);
            ck("deq_data", ack_data[0], deq_v[k]);
            ck("deq_valid", DW'(ack_val[0]), 1);
            ck("deq_latency", DW'(ack_cyc[0] - req_cyc[0]), RC + 1);
        end
        ck("empty_after_drain", DW'(q_empty), 1);

        RSTn = 1'b1;
        step();
        RSTn = 1'b0;
        ack_order.delete();
        n0 = ack_cnt[3];
        for (int i = 0; i < NR; i++) issue(i, 1, DW'(10 * (i + 1)));
        wait_ack(3, n0);
        ck("rr_first_latency", DW'(ack_cyc[0] - req_cyc[0]), 2);
        for (int k = 0; k < 4; k++) ck("rr_order", DW'(ack_order[k]), DW'(k));
        for (int k = 0; k < 3; k++) ck("rr_gap", DW'(ack_cyc[k+1] - ack_cyc[k]), 3);
        ck("full_after_rr", DW'(q_full), 1);

        w0 = qwrt_n;
        op(2, 1, 9);
        ck("full_err", DW'(ack_err[2]), 1);
        ck("full_err_latency", DW'(ack_cyc[2] - req_cyc[2]), 1);
        ck("full_no_qwrt", DW'(qwrt_n), DW'(w0));

        for (int k = 0; k < 4; k++) begin
            op(3, 0, '0);
            ck("drain_data", ack_data[3], DW'(10 * (k + 1)));
        end
        r0 = qread_n;
        op(1, 0, '0);
        ck("empty_err", DW'(ack_err[1]), 1);
        ck("empty_valid", DW'(ack_val[1]), 0);
        ck("empty_latency", DW'(ack_cyc[1] - req_cyc[1]), 1);
        ck("empty_no_qread", DW'(qread_n), DW'(r0));

        op(3, 1, 50);
        ack_order.delete();
        n0 = ack_cnt[3];
        issue(0, 1, 60);
        issue(3, 1, 70);
        wait_ack(3, n0);
        ck("wrap_first", DW'(ack_order[0]), 0);
        ck("wrap_second", DW'(ack_order[1]), 3);

        n0 = ack_cnt[2];
        issue(2, 0, '0);
        step();
        ck("deq_active", DW'(q_read), 1);
        RSTn = 1'b1;
        #1;
        ck("arst_req_ack", DW'(req_ack), '0);
        ck("arst_rsp_err", DW'(rsp_err), '0);
        ck("arst_rsp_valid", DW'(rsp_valid), '0);
        ck("arst_rsp_node_f", rsp_node_f, '0);
        ck("arst_q_wrt", DW'(q_wrt), '0);
        ck("arst_q_read", DW'(q_read), '0);
        ck("arst_q_valid", DW'(q_valid), '0);
        ck("arst_q_node_f", q_node_f, '0);
        step();
        ck("arst_no_ack", DW'(ack_cnt[2]), DW'(n0));
        RSTn = 1'b0;
        rel = cyc;
        wait_ack(2, n0);
        ck("reserve_data", ack_data[2], 50);
        ck("reserve_valid", DW'(ack_val[2]), 1);
        ck("reserve_latency", DW'(ack_cyc[2] - rel), RC + 1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
